// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared types, funct3 codes and access-width helpers for the load/store unit
package lsu_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2,
      S_DONE = 2'd3
   } lsu_state_e;

   typedef enum logic [1:0] {
      SZ_B = 2'd0,
      SZ_H = 2'd1,
      SZ_W = 2'd2
   } lsu_size_e;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   // Undefined funct3 codes fall through to a word access.
   function automatic lsu_size_e access_size(input logic [2:0] funct3);
      case (funct3)
         F3_B, F3_BU: return SZ_B;
         F3_H, F3_HU: return SZ_H;
         default:     return SZ_W;
      endcase
   endfunction

   // Byte offset actually used: low bits the width cannot honour are dropped.
   function automatic logic [1:0] access_offset(input logic [2:0] funct3, input logic [1:0] addr_lo);
      case (access_size(funct3))
         SZ_B:    return addr_lo;
         SZ_H:    return {addr_lo[1], 1'b0};
         default: return 2'b00;
      endcase
   endfunction

   function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
      case (access_size(funct3))
         SZ_H:    return addr_lo[0];
         SZ_W:    return addr_lo != 2'b00;
         default: return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/lsu_load_align.sv
// rtl/lsu_load_align.sv - extracts the addressed lanes of a read word and sign/zero extends them
module lsu_load_align
   import lsu_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [1:0]  offset,
   input  logic [2:0]  funct3,
   output logic [31:0] data
);

   logic [31:0] shifted;

   // drop the lanes below the accessed byte, then extend to 32 bits
   always_comb begin
      shifted = rdata >> {offset, 3'b000};
      case (funct3)
         F3_B:    data = {{24{shifted[7]}}, shifted[7:0]};
         F3_BU:   data = {24'h000000, shifted[7:0]};
         F3_H:    data = {{16{shifted[15]}}, shifted[15:0]};
         F3_HU:   data = {16'h0000, shifted[15:0]};
         default: data = shifted;
      endcase
   end

endmodule

// File: rtl/lsu_mem_stage.sv
// rtl/lsu_mem_stage.sv - MEM-stage load/store unit; define LSU_MISALIGN_TRAP_EN to trap misaligned accesses
module lsu_mem_stage
   import lsu_pkg::*;
#(
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   input  logic              req_we,
   input  logic [2:0]        req_funct3,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              stall,
   output logic              rsp_valid,
   output logic [31:0]       MemData,
   output logic              misalign,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [3:0]        mem_be,
   output logic [31:0]       mem_wdata,
   input  logic              mem_gnt,
   input  logic              mem_rvalid,
   input  logic [31:0]       mem_rdata
);

   lsu_state_e        state, state_next;
   logic              we_q;
   logic [2:0]        f3_q;
   logic [ADDR_W-1:0] addr_q;
   logic [31:0]       wdata_q;
   logic              accept;
   logic              load_en;
   logic [1:0]        offset;
   logic [3:0]        be;
   logic [31:0]       lanes;
   logic [31:0]       load_data;
   logic              mis_now;

   assign accept = (state == S_IDLE) && req_valid;
   assign offset = access_offset(f3_q, addr_q[1:0]);

`ifdef LSU_MISALIGN_TRAP_EN
   logic mis_q;

   assign mis_now  = is_misaligned(req_funct3, req_addr[1:0]);
   assign misalign = (state == S_DONE) && mis_q;

   // remember whether the accepted access trapped, for the DONE pulse
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      mis_q <= 1'b0;
      else if (accept) mis_q <= mis_now;
   end
`else
   assign mis_now  = 1'b0;
   assign misalign = 1'b0;
`endif

   // capture the access on acceptance; held for the whole bus transaction
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         we_q    <= 1'b0;
         f3_q    <= F3_B;
         addr_q  <= '0;
         wdata_q <= '0;
      end else if (accept) begin
         we_q    <= req_we;
         f3_q    <= req_funct3;
         addr_q  <= req_addr;
         wdata_q <= req_wdata;
      end
   end

   // byte enables and replicated store lanes for the latched access width
   always_comb begin
      be    = 4'b1111;
      lanes = wdata_q;
      case (access_size(f3_q))
         SZ_B: begin
            be    = 4'b0001 << offset;
            lanes = {4{wdata_q[7:0]}};
         end
         SZ_H: begin
            be    = 4'b0011 << offset;
            lanes = {2{wdata_q[15:0]}};
         end
         default: begin
            be    = 4'b1111;
            lanes = wdata_q;
         end
      endcase
   end

   lsu_load_align u_load_align (
      .rdata  (mem_rdata),
      .offset (offset),
      .funct3 (f3_q),
      .data   (load_data)
   );

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_next;
   end

   // next state, bus drive and pipeline handshake; bus outputs stay 0 outside REQ
   always_comb begin
      state_next = state;
      stall      = 1'b0;
      rsp_valid  = 1'b0;
      load_en    = 1'b0;
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      mem_addr   = '0;
      mem_be     = 4'b0000;
      mem_wdata  = 32'h0;
      case (state)
         S_IDLE: begin
            if (req_valid) begin
               stall      = 1'b1;
               state_next = mis_now ? S_DONE : S_REQ;
            end
         end
         S_REQ: begin
            stall     = 1'b1;
            mem_req   = 1'b1;
            mem_we    = we_q;
            mem_addr  = {addr_q[ADDR_W-1:2], 2'b00};
            mem_be    = be;
            mem_wdata = lanes;
            if (mem_gnt) state_next = we_q ? S_DONE : S_WAIT;
         end
         S_WAIT: begin
            stall = 1'b1;
            if (mem_rvalid) begin
               load_en    = 1'b1;
               state_next = S_DONE;
            end
         end
         default: begin
            // the core advances on this edge, so no new request is taken here
            rsp_valid  = 1'b1;
            state_next = S_IDLE;
         end
      endcase
   end

   // load result register, held until the next load returns
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)       MemData <= 32'h0;
      else if (load_en) MemData <= load_data;
   end

endmodule

// File: tb/tb_lsu_mem_stage.sv
// tb/tb_lsu_mem_stage.sv - randomized self-checking bench for lsu_mem_stage
module tb_lsu_mem_stage;

`ifdef LSU_MISALIGN_TRAP_EN
   localparam bit TRAP = 1'b1;
`else
   localparam bit TRAP = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_we = 1'b0;
   logic [2:0]  req_funct3 = 3'b000;
   logic [31:0] req_addr = 32'h0;
   logic [31:0] req_wdata = 32'h0;
   logic        mem_gnt = 1'b0;
   logic        mem_rvalid = 1'b0;
   logic [31:0] mem_rdata = 32'h0;

   logic        stall, rsp_valid, misalign, mem_req, mem_we;
   logic [31:0] MemData, mem_addr, mem_wdata;
   logic [3:0]  mem_be;

   int errors = 0;
   int checks = 0;

   logic        chk_en = 1'b0;
   logic        e_stall, e_rsp, e_mis, e_req, e_we;
   logic [31:0] e_addr, e_wdata, e_memdata;
   logic [3:0]  e_be;

   int          cyc = 0;
   int          rsp_cyc = 0;
   int          start_cyc = 0;
   int          lat = 0;
   int          stall_cnt = 0;
   int          rsp_cnt = 0;
   int          mis_cnt = 0;
   int          req_starts = 0;
   logic        prev_req = 1'b0;
   logic [3:0]  last_be = 4'h0;
   logic [31:0] last_addr = 32'h0;
   logic [31:0] last_wdata = 32'h0;
   logic        last_we = 1'b0;

   int          s0, r0, q0, m0;
   logic        r_we;
   logic [2:0]  r_f3;
   logic [31:0] r_addr, r_wd, r_rd;
   int          r_gw, r_rw;

   always #5 clk = ~clk;

   lsu_mem_stage #(.ADDR_W(32)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_we     (req_we),
      .req_funct3 (req_funct3),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .stall      (stall),
      .rsp_valid  (rsp_valid),
      .MemData    (MemData),
      .misalign   (misalign),
      .mem_req    (mem_req),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_be     (mem_be),
      .mem_wdata  (mem_wdata),
      .mem_gnt    (mem_gnt),
      .mem_rvalid (mem_rvalid),
      .mem_rdata  (mem_rdata)
   );

   // ---------------- behavioural model ----------------
   function automatic int m_size(input logic [2:0] f3);
      if (f3[1:0] == 2'b00) return 1;
      if (f3[1:0] == 2'b01) return 2;
      return 4;
   endfunction

   function automatic int m_off(input logic [2:0] f3, input logic [31:0] addr);
      int sz;
      sz = m_size(f3);
      return (int'(addr[1:0]) / sz) * sz;
   endfunction

   function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] addr);
      return 4'(((1 << m_size(f3)) - 1) << m_off(f3, addr));
   endfunction

   function automatic logic [31:0] m_lanes(input logic [2:0] f3, input logic [31:0] wd);
      case (m_size(f3))
         1:       return 32'(wd[7:0]) * 32'h01010101;
         2:       return 32'(wd[15:0]) * 32'h00010001;
         default: return wd;
      endcase
   endfunction

   function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] rd);
      int sz;
      logic [31:0] v, mask;
      sz = m_size(f3);
      v  = rd >> (8 * m_off(f3, addr));
      if (sz == 4) return v;
      mask = (32'h1 << (8 * sz)) - 32'h1;
      v = v & mask;
      if (f3[2] == 1'b0 && v[8*sz-1]) v = v | ~mask;
      return v;
   endfunction

   // ---------------- checking ----------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // per-cycle comparison against the model's expectations
   always @(negedge clk) begin
      if (chk_en) begin
         chk("stall",     32'(stall),     32'(e_stall));
         chk("rsp_valid", 32'(rsp_valid), 32'(e_rsp));
         chk("misalign",  32'(misalign),  32'(e_mis));
         chk("mem_req",   32'(mem_req),   32'(e_req));
         chk("mem_we",    32'(mem_we),    32'(e_we));
         chk("mem_addr",  mem_addr,       e_addr);
         chk("mem_be",    32'(mem_be),    32'(e_be));
         chk("mem_wdata", mem_wdata,      e_wdata);
         chk("MemData",   MemData,        e_memdata);
      end
   end

   always @(posedge clk) cyc <= cyc + 1;

   // event counters and last bus request snapshot
   always @(negedge clk) begin
      prev_req <= mem_req;
      if (stall)     stall_cnt <= stall_cnt + 1;
      if (misalign)  mis_cnt <= mis_cnt + 1;
      if (rsp_valid) begin
         rsp_cnt <= rsp_cnt + 1;
         rsp_cyc <= cyc;
      end
      if (mem_req && !prev_req) req_starts <= req_starts + 1;
      if (mem_req) begin
         last_be    <= mem_be;
         last_addr  <= mem_addr;
         last_wdata <= mem_wdata;
         last_we    <= mem_we;
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_quiet();
      e_stall = 1'b0; e_rsp = 1'b0; e_mis = 1'b0; e_req = 1'b0; e_we = 1'b0;
      e_addr = 32'h0; e_be = 4'h0; e_wdata = 32'h0;
   endtask

   task automatic noise();
      mem_gnt    = 1'($urandom);
      mem_rvalid = 1'($urandom);
      mem_rdata  = $urandom;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         req_valid = 1'b0;
         noise();
         set_quiet();
         tick();
      end
   endtask

   // one access: gw grant wait states, rw read wait states (after grant)
   task automatic do_txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [31:0] rd, input int gw, input int rw);
      int   sz;
      logic mis;
      sz  = m_size(f3);
      mis = TRAP && ((int'(addr[1:0]) % sz) != 0);
      start_cyc = cyc;
      req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
      noise();
      set_quiet(); e_stall = 1'b1;
      tick();
      if (!mis) begin
         for (int i = 0; i <= gw; i++) begin
            mem_gnt    = (i == gw);
            mem_rvalid = 1'($urandom);
            mem_rdata  = $urandom;
            set_quiet();
            e_stall = 1'b1; e_req = 1'b1; e_we = we;
            e_addr  = {addr[31:2], 2'b00};
            e_be    = m_be(f3, addr);
            e_wdata = m_lanes(f3, wd);
            tick();
         end
         if (!we) begin
            for (int i = 0; i <= rw; i++) begin
               mem_gnt    = 1'($urandom);
               mem_rvalid = (i == rw);
               mem_rdata  = (i == rw) ? rd : $urandom;
               set_quiet(); e_stall = 1'b1;
               tick();
            end
            e_memdata = m_load(f3, addr, rd);
         end
      end
      // completion cycle: a request offered here must not be taken
      req_valid = 1'($urandom); req_we = 1'($urandom); req_funct3 = 3'($urandom);
      req_addr = $urandom; req_wdata = $urandom;
      noise();
      set_quiet(); e_rsp = 1'b1; e_mis = mis;
      tick();
      lat = rsp_cyc - start_cyc;
      req_valid = 1'b0;
      set_quiet();
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      set_quiet();
      e_memdata = 32'h0;
      chk_en = 1'b1;
      rst_n = 1'b0;
      repeat (3) tick();
      rst_n = 1'b1;
      idle(2);

      // LB 0x101
      do_txn(1'b0, 3'b000, 32'h0000_0101, 32'h0, 32'h1234_80FF, 0, 0);
      chk("lb_be", 32'(last_be), 32'h2);
      chk("lb_latency", 32'(lat), 32'd3);
      chk("lb_memdata", MemData, 32'hFFFF_FF80);

      // LHU 0x202
      do_txn(1'b0, 3'b101, 32'h0000_0202, 32'h0, 32'hBEEF_1234, 0, 0);
      chk("lhu_be", 32'(last_be), 32'hC);
      chk("lhu_memdata", MemData, 32'h0000_BEEF);

      // SB 0x103
      do_txn(1'b1, 3'b000, 32'h0000_0103, 32'h0000_00AB, 32'h0, 0, 0);
      chk("sb_be", 32'(last_be), 32'h8);
      chk("sb_wdata", last_wdata, 32'hABAB_ABAB);
      chk("sb_we", 32'(last_we), 32'h1);
      chk("sb_latency", 32'(lat), 32'd2);
      chk("sb_memdata", MemData, 32'h0000_BEEF);

      // LW with 3 grant wait states and rvalid two cycles after grant
      s0 = stall_cnt; r0 = rsp_cnt; q0 = req_starts;
      do_txn(1'b0, 3'b010, 32'h0000_0100, 32'h0, 32'hCAFE_F00D, 3, 1);
      idle(2);
      chk("lw_wait_stall_cycles", 32'(stall_cnt - s0), 32'd7);
      chk("lw_wait_rsp_pulses", 32'(rsp_cnt - r0), 32'd1);
      chk("lw_wait_bus_requests", 32'(req_starts - q0), 32'd1);
      chk("lw_wait_latency", 32'(lat), 32'd7);
      chk("lw_wait_memdata", MemData, 32'hCAFE_F00D);

      // LW at 0x102
      q0 = req_starts; m0 = mis_cnt;
      do_txn(1'b0, 3'b010, 32'h0000_0102, 32'h0, 32'h5555_AAAA, 0, 0);
      idle(1);
`ifdef LSU_MISALIGN_TRAP_EN
      chk("trap_bus_requests", 32'(req_starts - q0), 32'd0);
      chk("trap_misalign_pulses", 32'(mis_cnt - m0), 32'd1);
      chk("trap_latency", 32'(lat), 32'd1);
      chk("trap_memdata", MemData, 32'hCAFE_F00D);
`else
      chk("unaligned_lw_addr", last_addr, 32'h0000_0100);
      chk("unaligned_lw_be", 32'(last_be), 32'hF);
      chk("unaligned_lw_memdata", MemData, 32'h5555_AAAA);
      chk("unaligned_lw_misalign", 32'(mis_cnt - m0), 32'd0);
`endif

      // randomized traffic
      for (int n = 0; n < 150; n++) begin
         r_we   = 1'($urandom);
         r_f3   = 3'($urandom);
         r_addr = $urandom;
         r_wd   = $urandom;
         r_rd   = $urandom;
         r_gw   = int'($urandom_range(0, 3));
         r_rw   = int'($urandom_range(0, 3));
         do_txn(r_we, r_f3, r_addr, r_wd, r_rd, r_gw, r_rw);
         if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 2)));
      end

      // reset during WAIT, then a late read response
      idle(1);
      chk_en = 1'b0;
      req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h0000_0400;
      mem_gnt = 1'b0; mem_rvalid = 1'b0;
      tick();
      mem_gnt = 1'b1;
      tick();
      mem_gnt = 1'b0;
      chk("rst_pre_stall", 32'(stall), 32'h1);
      #2;
      rst_n = 1'b0;
      req_valid = 1'b0;
      #1;
      chk("rst_mem_req", 32'(mem_req), 32'h0);
      chk("rst_stall", 32'(stall), 32'h0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
      chk("rst_mem_addr", mem_addr, 32'h0);
      chk("rst_mem_be", 32'(mem_be), 32'h0);
      chk("rst_MemData", MemData, 32'h0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      e_memdata = 32'h0;
      set_quiet();
      chk_en = 1'b1;
      for (int i = 0; i < 3; i++) begin
         mem_rvalid = 1'b1;
         mem_rdata  = $urandom | 32'h1;
         tick();
      end
      mem_rvalid = 1'b0;
      chk("rst_late_rvalid_memdata", MemData, 32'h0);

      // the unit works normally after reset
      do_txn(1'b0, 3'b001, 32'h0000_0806, 32'h0, 32'h8001_7FFF, 1, 0);
      chk("post_rst_lh_memdata", MemData, 32'hFFFF_8001);
      idle(2);

      chk_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/lsu_mem_stage.md
# lsu_mem_stage

Load/store unit for the MEM stage. It turns a load or store from the EX/MEM boundary into a request on the data-memory bus, generates byte enables and store-data lanes, and waits through bus wait states while stalling the pipeline. For loads it aligns and sign- or zero-extends the returned word into `MemData`, which feeds the write-back select directly downstream (`MemToReg = 2'b10`).

## Interface
- `ADDR_W`, 32, byte-address width.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `req_valid` input 1: a load or store is present; held stable by the core while `stall` is high.
- `req_we` input 1: 1 = store, 0 = load.
- `req_funct3` input 3: RV32I width/sign code (000 B, 001 H, 010 W, 100 BU, 101 HU).
- `req_addr` input ADDR_W: byte address.
- `req_wdata` input 32: store data, right-justified.
- `stall` output 1: freezes the upstream pipeline.
- `rsp_valid` output 1: one-cycle pulse when the access completes.
- `MemData` output 32: aligned and extended load result, held until the next load completes.
- `misalign` output 1: pulses with `rsp_valid` on a trapped misaligned access.
- `mem_req` output 1: bus request.
- `mem_we` output 1: bus write enable.
- `mem_addr` output ADDR_W: word-aligned address (`[1:0]` = 0).
- `mem_be` output 4: byte enables.
- `mem_wdata` output 32: lane-replicated store data.
- `mem_gnt` input 1: bus accepts the request.
- `mem_rvalid` input 1: read data valid.
- `mem_rdata` input 32: read data.

## Operation
- States: IDLE, REQ, WAIT, DONE.
- IDLE
  - On `req_valid`: latch `we`, `funct3`, `addr` and `wdata`, then go to REQ.
  - Misaligned access with trapping compiled in: go to DONE instead.
- REQ
  - `mem_req` = 1; all bus outputs driven from the latched fields.
  - On `mem_gnt`: a load goes to WAIT, a store goes to DONE.
- WAIT
  - On `mem_rvalid`: register the extracted data into `MemData`, go to DONE.
- DONE
  - `rsp_valid` = 1 for one cycle, then go to IDLE.
  - The request is not re-accepted in this cycle, because the core advances on the same edge.
- `stall` = (IDLE & `req_valid`) | REQ | WAIT. It is low in DONE.
- Byte enables:
  - Byte access: `4'b0001 << addr[1:0]`.
  - Half access: `4'b0011 << {addr[1],1'b0}`.
  - Word access: `4'b1111`.
- Store data lanes: byte access uses `{4{wdata[7:0]}}`; half access uses `{2{wdata[15:0]}}`.
- Load extraction:
  - Shift `mem_rdata` right by 8 × offset, using the same offsets as the byte enables.
  - Extend bit 7 for B, bit 15 for H; zero-extend for BU and HU.
- Undefined `funct3` values (011, 110, 111) are treated as W.
- Ignored inputs: `mem_gnt` outside REQ and `mem_rvalid` outside WAIT.
- Bus outputs are 0 while `mem_req` = 0.

## Timing
- Reset value of every output, including `MemData`, is 0. The state resets to IDLE.
- Reset is asynchronous: `mem_req` drops immediately. A bus response that arrives after reset is ignored.
- Accepting a request in cycle 0 gives REQ in cycle 1.
- Minimum latency: store 2 cycles (`rsp_valid` in cycle 2); load 3 cycles (`mem_rvalid` in cycle 2, `rsp_valid` in cycle 3).
- Each bus wait state adds one cycle.
- While waiting for `mem_gnt`, `mem_addr`, `mem_be`, `mem_wdata` and `mem_we` stay stable.
- `MemData` is valid from the `rsp_valid` cycle onward.

## Configuration
- Macro: `LSU_MISALIGN_TRAP_EN`.
- Misaligned means a half access with `addr[0]` = 1, or a word access with `addr[1:0]` ≠ 0.
- Defined:
  - A misaligned access issues no bus request and goes IDLE → DONE.
  - `misalign` = 1 and `rsp_valid` = 1 in DONE.
  - `MemData` is unchanged.
- Undefined:
  - `misalign` is tied to 0.
  - The low address bits the access width cannot honour are ignored, so the access is issued aligned down.

## Structure
- Package `lsu_pkg` holds:
  - the state enum `lsu_state_e`;
  - the `funct3` localparams (`F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`).
- Sub-module `lsu_load_align` holds the combinational extraction and extension: inputs `rdata`, `offset`, `funct3`; output 32-bit data.
- The FSM, latches and byte-enable logic live in the top module.

## Test plan
- LB at address 0x101 with `mem_rdata` 0x1234_80FF, no wait states → `mem_be` 0010, `rsp_valid` in cycle 3, `MemData` 0xFFFF_FF80.
- LHU at address 0x202 with `mem_rdata` 0xBEEF_1234 → `mem_be` 1100, `MemData` 0x0000_BEEF.
- SB at address 0x103 with `req_wdata` 0x0000_00AB → `mem_be` 1000, `mem_wdata` 0xABAB_ABAB, `mem_we` 1, `rsp_valid` 2 cycles after accept, `MemData` unchanged.
- LW with `mem_gnt` delayed 3 cycles and `mem_rvalid` delayed 2 cycles → `mem_req` and `mem_addr` stable throughout, `stall` high for 7 cycles, one `rsp_valid` pulse, no second bus request.
- LW at address 0x102 with `LSU_MISALIGN_TRAP_EN` defined → `mem_req` never asserted, `misalign` and `rsp_valid` pulse in cycle 1.
- Same LW without the macro → `mem_addr` 0x100, `mem_be` 1111.
- `rst_n` low while in WAIT, then a late `mem_rvalid` → all outputs 0 immediately, FSM in IDLE, late `mem_rvalid` ignored, `MemData` stays 0.
